// File: rtl/seq_match_pkg.sv
// Shared types and defaults for the serial pattern-match controller.
package seq_match_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEF_DW = 16;
    localparam int DEF_PW = 4;
    localparam int DEF_CW = 5;

    // Smallest CW with 2^CW-1 >= DW-PW+1 (most matches one word can hold)
    function automatic int min_cw(input int dw, input int pw);
        return $clog2(dw - pw + 2);
    endfunction

endpackage

// File: rtl/seq_win_det.sv
// PW-bit sliding window detector; SEQ_MATCH_NONOVERLAP_EN restarts
// the window after each hit so matches never share bits.
module seq_win_det
    import seq_match_pkg::*;
#(
    parameter int PW = DEF_PW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          bit_i,
    input  logic [PW-1:0] pat_i,
    output logic          hit_o
);

    localparam int FW = $clog2(PW + 1);
    localparam logic [FW:0] PW_W = (FW + 1)'(PW);

    logic [PW-1:0] win_q, win_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [FW:0]   fill_inc;

    always_comb begin
        win_d    = {win_q[PW-2:0], bit_i};
        fill_inc = {1'b0, fill_q} + {{FW{1'b0}}, 1'b1};
        fill_d   = (fill_inc > PW_W) ? fill_q : fill_inc[FW-1:0];
        hit_o    = en_i && (fill_inc >= PW_W) && (win_d == pat_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q  <= '0;
            fill_q <= '0;
        end else if (clr_i) begin
            win_q  <= '0;
            fill_q <= '0;
        end else if (en_i) begin
`ifdef SEQ_MATCH_NONOVERLAP_EN
            if (hit_o) begin
                win_q  <= '0;
                fill_q <= '0;
            end else begin
                win_q  <= win_d;
                fill_q <= fill_d;
            end
`else
            win_q  <= win_d;
            fill_q <= fill_d;
`endif
        end
    end

endmodule

// File: rtl/seq_match_ctrl.sv
// Serialises a word MSB-first through seq_win_det and counts matches.
// Build option SEQ_MATCH_NONOVERLAP_EN selects non-overlapping counting.
module seq_match_ctrl
    import seq_match_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int PW = DEF_PW,
    parameter int CW = DEF_CW
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic [DW-1:0] DIN,
    input  logic [PW-1:0] PAT,
    output logic          BUSY,
    output logic          DONE,
    output logic          SBIT,
    output logic          ZSER,
    output logic [CW-1:0] MCNT
);

    localparam int BW = $clog2(DW + 1);

    state_e        state_q;
    logic [DW-1:0] sreg_q;
    logic [PW-1:0] pat_q;
    logic [BW-1:0] bcnt_q;
    logic [CW-1:0] mcnt_q;
    logic          busy_q, done_q, sbit_q, zser_q;
    logic          accept, shift_en, hit;

    assign accept   = (state_q == ST_IDLE) && START;
    assign shift_en = (state_q == ST_SHIFT);

    seq_win_det #(
        .PW (PW)
    ) u_det (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .clr_i  (accept),
        .en_i   (shift_en),
        .bit_i  (sreg_q[DW-1]),
        .pat_i  (pat_q),
        .hit_o  (hit)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            pat_q   <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sbit_q  <= 1'b0;
            zser_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            zser_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        sreg_q  <= DIN;
                        pat_q   <= PAT;
                        mcnt_q  <= '0;
                        bcnt_q  <= BW'(DW);
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sreg_q <= {sreg_q[DW-2:0], 1'b0};
                    sbit_q <= sreg_q[DW-1];
                    bcnt_q <= bcnt_q - BW'(1);
                    if (hit) begin
                        zser_q <= 1'b1;
                        if (mcnt_q != '1) mcnt_q <= mcnt_q + CW'(1);
                    end
                    // last bit consumed on this edge
                    if (bcnt_q == BW'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign SBIT = sbit_q;
    assign ZSER = zser_q;
    assign MCNT = mcnt_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl (default DW=16, PW=4, CW=5).
module tb_seq_match_ctrl;

    localparam int DW = 16;
    localparam int PW = 4;
    localparam int CW = 5;

`ifdef SEQ_MATCH_NONOVERLAP_EN
    localparam int EXP_AAAA = 4;
    localparam int EXP_FFFF = 4;
    localparam int EXP_RST8 = 2;
`else
    localparam int EXP_AAAA = 7;
    localparam int EXP_FFFF = 13;
    localparam int EXP_RST8 = 3;
`endif

    logic          CLK;
    logic          RST_N;
    logic          START;
    logic [DW-1:0] DIN;
    logic [PW-1:0] PAT;
    logic          BUSY, DONE, SBIT, ZSER;
    logic [CW-1:0] MCNT;

    int n_tests = 0;
    int n_fail  = 0;

    int   z_pulses, first_z, done_first, done_pulses;
    logic busy_acc, busy_end, sb1, sb2;

    seq_match_ctrl #(
        .DW (DW),
        .PW (PW),
        .CW (CW)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .DIN   (DIN),
        .PAT   (PAT),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SBIT  (SBIT),
        .ZSER  (ZSER),
        .MCNT  (MCNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Accept a job at edge 0, then observe edges 1..20 at +1 time unit.
    // inj_k > 0 pulses START with a different word just before edge inj_k.
    task automatic run_job(input logic [15:0] d, input logic [3:0] p,
                           input int inj_k);
        @(negedge CLK);
        DIN = d;
        PAT = p;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        busy_acc = BUSY;
        z_pulses = 0;
        first_z = -1;
        done_first = -1;
        done_pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == inj_k) begin
                @(negedge CLK);
                START = 1'b1;
                DIN = 16'hFFFF;
                PAT = 4'hF;
            end
            @(posedge CLK);
            #1;
            if (k == inj_k) START = 1'b0;
            if (ZSER) begin
                z_pulses++;
                if (first_z < 0) first_z = k;
            end
            if (DONE) begin
                done_pulses++;
                if (done_first < 0) done_first = k;
            end
            if (k == 1) sb1 = SBIT;
            if (k == 2) sb2 = SBIT;
            if (k == DW + 1) busy_end = BUSY;
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b0;
        DIN = '0;
        PAT = '0;
        repeat (3) @(posedge CLK);
        #1;
        n_tests++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: got %b expected 0", BUSY);
        end
        n_tests++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_done: got %b expected 0", DONE);
        end
        n_tests++;
        if (SBIT !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_sbit: got %b expected 0", SBIT);
        end
        n_tests++;
        if (ZSER !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_zser: got %b expected 0", ZSER);
        end
        n_tests++;
        if (MCNT !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_mcnt: got %0d expected 0", MCNT);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);
    endtask

    task automatic test_alternating();
        run_job(16'hAAAA, 4'b1010, -1);
        n_tests++;
        if (busy_acc !== 1'b1) begin
            n_fail++;
            $display("FAIL aaaa_busy_acc: got %b expected 1", busy_acc);
        end
        n_tests++;
        if (sb1 !== 1'b1 || sb2 !== 1'b0) begin
            n_fail++;
            $display("FAIL aaaa_sbit: got %b%b expected 10", sb1, sb2);
        end
        n_tests++;
        if (z_pulses != EXP_AAAA) begin
            n_fail++;
            $display("FAIL aaaa_zser: got %0d expected %0d", z_pulses, EXP_AAAA);
        end
        n_tests++;
        if (MCNT !== 5'(EXP_AAAA)) begin
            n_fail++;
            $display("FAIL aaaa_mcnt: got %0d expected %0d", MCNT, EXP_AAAA);
        end
        n_tests++;
        if (done_first != DW || done_pulses != 1) begin
            n_fail++;
            $display("FAIL aaaa_done: got edge %0d x%0d expected edge %0d x1",
                     done_first, done_pulses, DW);
        end
        n_tests++;
        if (busy_end !== 1'b0) begin
            n_fail++;
            $display("FAIL aaaa_busy_end: got %b expected 0", busy_end);
        end
    endtask

    task automatic test_all_ones();
        run_job(16'hFFFF, 4'hF, -1);
        n_tests++;
        if (MCNT !== 5'(EXP_FFFF)) begin
            n_fail++;
            $display("FAIL ffff_mcnt: got %0d expected %0d", MCNT, EXP_FFFF);
        end
        n_tests++;
        if (first_z != PW) begin
            n_fail++;
            $display("FAIL ffff_first_z: got edge %0d expected %0d", first_z, PW);
        end
        n_tests++;
        if (z_pulses != EXP_FFFF) begin
            n_fail++;
            $display("FAIL ffff_zser: got %0d expected %0d", z_pulses, EXP_FFFF);
        end
    endtask

    task automatic test_no_match();
        run_job(16'h0000, 4'b1011, -1);
        n_tests++;
        if (MCNT !== 5'd0) begin
            n_fail++;
            $display("FAIL zero_mcnt: got %0d expected 0", MCNT);
        end
        n_tests++;
        if (z_pulses != 0) begin
            n_fail++;
            $display("FAIL zero_zser: got %0d expected 0", z_pulses);
        end
        n_tests++;
        if (done_pulses != 1 || done_first != DW) begin
            n_fail++;
            $display("FAIL zero_done: got edge %0d x%0d expected edge %0d x1",
                     done_first, done_pulses, DW);
        end
        n_tests++;
        if (busy_end !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy_end: got %b expected 0", busy_end);
        end
    endtask

    task automatic test_start_ignored();
        run_job(16'hAAAA, 4'b1010, 5);
        n_tests++;
        if (MCNT !== 5'(EXP_AAAA)) begin
            n_fail++;
            $display("FAIL midstart_mcnt: got %0d expected %0d", MCNT, EXP_AAAA);
        end
        n_tests++;
        if (done_pulses != 1 || done_first != DW) begin
            n_fail++;
            $display("FAIL midstart_done: got edge %0d x%0d expected edge %0d x1",
                     done_first, done_pulses, DW);
        end
    endtask

    task automatic test_async_reset();
        @(negedge CLK);
        DIN = 16'hAAAA;
        PAT = 4'b1010;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        n_tests++;
        if (MCNT !== 5'(EXP_RST8)) begin
            n_fail++;
            $display("FAIL arst_pre_mcnt: got %0d expected %0d", MCNT, EXP_RST8);
        end
        #2;
        RST_N = 1'b0;
        #1;
        n_tests++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_busy: got %b expected 0", BUSY);
        end
        n_tests++;
        if (DONE !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_done: got %b expected 0", DONE);
        end
        n_tests++;
        if (ZSER !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_zser: got %b expected 0", ZSER);
        end
        n_tests++;
        if (MCNT !== 5'd0) begin
            n_fail++;
            $display("FAIL arst_mcnt: got %0d expected 0", MCNT);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        run_job(16'hFFFF, 4'hF, -1);
        n_tests++;
        if (MCNT !== 5'(EXP_FFFF) || done_pulses != 1) begin
            n_fail++;
            $display("FAIL arst_rerun: got mcnt %0d done x%0d expected %0d x1",
                     MCNT, done_pulses, EXP_FFFF);
        end
    endtask

    task automatic test_back_to_back();
        int d0, d1, nd;
        logic [CW-1:0] m_pre, m_acc;
        d0 = -1;
        d1 = -1;
        nd = 0;
        m_pre = '0;
        m_acc = '1;
        @(negedge CLK);
        DIN = 16'hAAAA;
        PAT = 4'b1010;
        START = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                nd++;
                if (d0 < 0) d0 = k;
                else if (d1 < 0) d1 = k;
            end
            if (k == DW + 1) m_pre = MCNT;
            if (k == DW + 2) m_acc = MCNT;
        end
        START = 1'b0;
        n_tests++;
        if (d1 - d0 != DW + 2) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d expected %0d", d1 - d0, DW + 2);
        end
        n_tests++;
        if (nd != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d expected 2", nd);
        end
        n_tests++;
        if (m_pre !== 5'(EXP_AAAA)) begin
            n_fail++;
            $display("FAIL b2b_mcnt_first: got %0d expected %0d", m_pre, EXP_AAAA);
        end
        n_tests++;
        if (m_acc !== 5'd0) begin
            n_fail++;
            $display("FAIL b2b_mcnt_clear: got %0d expected 0", m_acc);
        end
        for (int k = 0; k < 40 && BUSY; k++) @(posedge CLK);
        #1;
        n_tests++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: got busy %b expected 0", BUSY);
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_all_ones();
        test_no_match();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
